// File: rtl/rmw_sequencer_pkg.sv
// rmw_sequencer_pkg: ALU op codes, status flag indices and decode record shared by the RMW sequencer
package rmw_sequencer_pkg;
    localparam logic [4:0] ALU_FLG = 5'd0;
    localparam logic [4:0] ALU_ASL = 5'd1;
    localparam logic [4:0] ALU_LSR = 5'd2;
    localparam logic [4:0] ALU_ROL = 5'd3;
    localparam logic [4:0] ALU_ROR = 5'd4;
    localparam logic [4:0] ALU_INC = 5'd5;

    localparam int CARRY_FLAG    = 0;
    localparam int ZERO_FLAG     = 1;
    localparam int NEGATIVE_FLAG = 6;

    localparam logic [6:0] C_MASK  = 7'(1 << CARRY_FLAG);
    localparam logic [6:0] ZN_MASK = 7'((1 << ZERO_FLAG) | (1 << NEGATIVE_FLAG));

    typedef struct packed {
        logic       legal;
        logic       zp;
        logic [4:0] op;
    } decode_t;
endpackage

// File: rtl/rmw_sequencer_if.sv
// rmw_sequencer_if: instruction request, memory bus, ALU and acc/status writeback signals
// master: the CPU-side environment (request, memory, ALU, register file)
// slave:  the sequencer itself
interface rmw_sequencer_if;
    logic        start;
    logic [7:0]  opcode;
    logic [7:0]  operand;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] mem_addr;
    logic        mem_rw;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic [4:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [6:0]  alu_flags_in;
    logic [7:0]  alu_result;
    logic [6:0]  alu_flags;
    logic [7:0]  acc_in;
    logic [7:0]  acc_out;
    logic        acc_we;
    logic [6:0]  status_in;
    logic [6:0]  status_out;
    logic        status_we;

    modport master (
        output start, opcode, operand, mem_data_in, alu_result, alu_flags, acc_in, status_in,
        input  busy, done, illegal, mem_addr, mem_rw, mem_data_out, alu_op, alu_a, alu_b,
               alu_flags_in, acc_out, acc_we, status_out, status_we
    );

    modport slave (
        input  start, opcode, operand, mem_data_in, alu_result, alu_flags, acc_in, status_in,
        output busy, done, illegal, mem_addr, mem_rw, mem_data_out, alu_op, alu_a, alu_b,
               alu_flags_in, acc_out, acc_we, status_out, status_we
    );
endinterface

// File: rtl/rmw_sequencer.sv
// rmw_sequencer: sequences 6502 ASL/LSR/ROL/ROR (accumulator and zero page) and INC zero page
// Ports: clk, rst (asynchronous, active high)
//        bus (slave): start/opcode/operand request, busy/done/illegal status,
//        zero-page memory bus, external registered ALU, accumulator and status writeback
module rmw_sequencer
    import rmw_sequencer_pkg::*;
(
    input logic            clk,
    input logic            rst,
    rmw_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, DUMMY, WRITE, ACC_WB} state_t;

    state_t     state, state_n;
    logic [7:0] operand_q, orig_q, result_q;
    logic [6:0] flags_q, flag_src, mask;
    logic [4:0] op_q;
    logic       zp_q, illegal_q, mem_st, wb;
    decode_t    dec;

    function automatic decode_t decode(input logic [7:0] opc);
        case (opc)
            8'h0A:   decode = '{1'b1, 1'b0, ALU_ASL};
            8'h4A:   decode = '{1'b1, 1'b0, ALU_LSR};
            8'h2A:   decode = '{1'b1, 1'b0, ALU_ROL};
            8'h6A:   decode = '{1'b1, 1'b0, ALU_ROR};
            8'h06:   decode = '{1'b1, 1'b1, ALU_ASL};
            8'h46:   decode = '{1'b1, 1'b1, ALU_LSR};
            8'h26:   decode = '{1'b1, 1'b1, ALU_ROL};
            8'h66:   decode = '{1'b1, 1'b1, ALU_ROR};
            8'hE6:   decode = '{1'b1, 1'b1, ALU_INC};
            default: decode = '{1'b0, 1'b0, ALU_FLG};
        endcase
    endfunction

    assign dec = decode(bus.opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            illegal_q <= 1'b0;
            operand_q <= '0;
            op_q      <= ALU_FLG;
            zp_q      <= 1'b0;
            orig_q    <= '0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state     <= state_n;
            // illegal opcodes finish in the following cycle while staying in IDLE
            illegal_q <= state == IDLE && bus.start && !dec.legal;
            if (state == IDLE && bus.start) begin
                operand_q <= bus.operand;
                op_q      <= dec.op;
                zp_q      <= dec.zp;
            end
            if (state == EXEC)
                orig_q <= bus.mem_data_in;
            if (state == DUMMY) begin
                result_q <= bus.alu_result;
                flags_q  <= bus.alu_flags;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start && dec.legal ? (dec.zp ? READ : EXEC) : IDLE;
            READ:    state_n = EXEC;
            EXEC:    state_n = zp_q ? DUMMY : ACC_WB;
            DUMMY:   state_n = WRITE;
            default: state_n = IDLE;
        endcase
    end

    assign mem_st   = state inside {READ, DUMMY, WRITE};
    assign wb       = state == WRITE || state == ACC_WB;
    // accumulator path uses the ALU flags live; zero page uses the copy taken during DUMMY
    assign flag_src = state == ACC_WB ? bus.alu_flags : flags_q;
    // INC leaves carry untouched
    assign mask     = ZN_MASK | (op_q == ALU_INC ? 7'h00 : C_MASK);

    assign bus.busy         = state != IDLE;
    assign bus.done         = illegal_q || wb;
    assign bus.illegal      = illegal_q;
    assign bus.mem_addr     = mem_st ? {8'h00, operand_q} : 16'h0000;
    assign bus.mem_rw       = !(state == DUMMY || state == WRITE);
    assign bus.mem_data_out = state == DUMMY ? orig_q : state == WRITE ? result_q : 8'h00;
    assign bus.alu_op       = state == EXEC ? op_q : ALU_FLG;
    assign bus.alu_a        = state == EXEC ? (zp_q ? bus.mem_data_in : bus.acc_in) : 8'h00;
    assign bus.alu_b        = 8'h00;
    assign bus.alu_flags_in = bus.status_in;
    assign bus.acc_out      = state == ACC_WB ? bus.alu_result : 8'h00;
    assign bus.acc_we       = state == ACC_WB;
    assign bus.status_we    = wb;
    assign bus.status_out   = wb ? (bus.status_in & ~mask) | (flag_src & mask) : 7'h00;
endmodule
